// File: rtl/rv_encoder.sv
// rtl/rv_encoder.sv - RV32I/Zicsr instruction encoder with li pseudo-op expansion
module rv_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_li,
    input  logic [4:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic        out_last,
    output logic        err
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_SYS = 3'd6;
    localparam logic [2:0] FMT_BAD = 3'd7;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    logic [0:0]  state;
    logic [31:0] pend_insn;
    logic [6:0]  op7;
    logic [2:0]  fmt;
    logic        fits_i;
    logic        fits_b;
    logic        fits_j;
    logic        low12_zero;
    logic        enc_err;
    logic [31:0] enc_insn;
    logic [19:0] li_hi;
    logic        li_two;
    logic [31:0] li_first;
    logic [31:0] li_second;
    logic        can_load;
    logic        accept;

    assign op7      = {in_opcode, 2'b11};
    assign can_load = !out_valid || out_ready;
    assign in_ready = !reset && (state == ST_IDLE) && can_load;
    assign accept   = in_valid && in_ready;

    always_comb begin
        fmt = FMT_BAD;
        casez (in_opcode)
            5'b011?0:                              fmt = FMT_R;
            5'b00000, 5'b00011, 5'b001?0, 5'b11001: fmt = FMT_I;
            5'b01000:                              fmt = FMT_S;
            5'b11000:                              fmt = FMT_B;
            5'b0?101:                              fmt = FMT_U;
            5'b11011:                              fmt = FMT_J;
            5'b11100:                              fmt = FMT_SYS;
            default:                               fmt = FMT_BAD;
        endcase
    end

    // A value fits an N-bit signed field when every bit above the field's sign bit matches it.
    assign fits_i     = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign fits_b     = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
    assign fits_j     = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
    assign low12_zero = !(|in_imm[11:0]);

    always_comb begin
        enc_insn = 32'h0;
        enc_err  = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_insn = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, op7};
            end
            FMT_I: begin
                enc_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, op7};
                enc_err  = !fits_i;
            end
            FMT_S: begin
                enc_insn = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], op7};
                enc_err  = !fits_i;
            end
            FMT_B: begin
                enc_insn = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], op7};
                enc_err  = !fits_b;
            end
            FMT_U: begin
                enc_insn = {in_imm[31:12], in_rd, op7};
                enc_err  = !low12_zero;
            end
            FMT_J: begin
                enc_insn = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op7};
                enc_err  = !fits_j;
            end
            FMT_SYS: begin
                if (in_funct3 == 3'b000) begin
                    enc_insn = {in_imm[11:0], 5'd0, 3'b000, 5'd0, OP_SYS};
                    enc_err  = !fits_i;
                end else begin
                    enc_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_SYS};
                    enc_err  = (in_funct3 == 3'b100);
                end
            end
            default: begin
                enc_err = 1'b1;
            end
        endcase
    end

    // lo = sext(imm[11:0]) is negative exactly when imm[11] is set, so imm - lo bumps the upper part by one.
    assign li_hi     = in_imm[31:12] + {19'd0, in_imm[11]};
    assign li_two    = !fits_i && !low12_zero;
    assign li_first  = fits_i ? {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_ADDI}
                              : {li_hi, in_rd, OP_LUI};
    assign li_second = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_ADDI};

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            pend_insn <= 32'h0;
            out_valid <= 1'b0;
            out_insn  <= 32'h0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == ST_PEND) begin
                if (can_load) begin
                    out_valid <= 1'b1;
                    out_insn  <= pend_insn;
                    out_last  <= 1'b1;
                    state     <= ST_IDLE;
                end
            end else if (accept) begin
                if (in_li) begin
                    out_valid <= 1'b1;
                    out_insn  <= li_first;
                    out_last  <= !li_two;
                    if (li_two) begin
                        pend_insn <= li_second;
                        state     <= ST_PEND;
                    end
                end else if (enc_err) begin
                    err       <= 1'b1;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                    out_insn  <= enc_insn;
                    out_last  <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv_encoder.sv
// tb/tb_rv_encoder.sv - self-checking bench for rv_encoder with a field-level round-trip model
module tb_rv_encoder;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_li;
    logic [4:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_insn;
    logic        out_last;
    logic        err;

    rv_encoder dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_li     (in_li),
        .in_opcode (in_opcode),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_insn  (out_insn),
        .out_last  (out_last),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          raw;
        logic [31:0] word;
        logic        last;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_seen = 0;
    int   err_exp  = 0;
    int   ready_mode = 0;
    bit   hold_prev = 0;
    logic [31:0] prev_insn;
    logic        prev_last;

    logic [4:0] r_ops [2]   = '{5'b01100, 5'b01110};
    logic [4:0] i_ops [5]   = '{5'b00000, 5'b00011, 5'b00100, 5'b00110, 5'b11001};
    logic [4:0] u_ops [2]   = '{5'b00101, 5'b01101};
    logic [4:0] bad_ops [6] = '{5'b00001, 5'b00010, 5'b01011, 5'b10100, 5'b11111, 5'b01111};
    int         li_special [8] = '{2047, 2048, -2048, -2049, 32'h7FFFFFFF, 32'h80000000,
                                   32'h7FFFF800, -1};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic exp_t mk_raw(input logic [31:0] w, input logic last);
        exp_t e;
        e = '{raw: 1'b1, word: w, last: last, op: 5'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
              f3: 3'd0, f7: 7'd0, imm: 32'd0};
        return e;
    endfunction

    function automatic exp_t mk_fld(input logic [4:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] imm, input logic last);
        exp_t e;
        e = '{raw: 1'b0, word: 32'd0, last: last, op: op, rd: rd, rs1: rs1, rs2: rs2,
              f3: f3, f7: f7, imm: imm};
        return e;
    endfunction

    // Independent instruction decoder: recovers fields and the signed immediate from a word.
    function automatic exp_t decode(input logic [31:0] w);
        exp_t d;
        d = mk_fld(w[6:2], 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        case (w[6:2])
            5'b01100, 5'b01110: begin
                d.rd = w[11:7]; d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.f7 = w[31:25];
            end
            5'b00000, 5'b00011, 5'b00100, 5'b00110, 5'b11001: begin
                d.rd = w[11:7]; d.f3 = w[14:12]; d.rs1 = w[19:15];
                d.imm = {{20{w[31]}}, w[31:20]};
            end
            5'b01000: begin
                d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            5'b11000: begin
                d.f3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
                d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            5'b00101, 5'b01101: begin
                d.rd = w[11:7]; d.imm = {w[31:12], 12'd0};
            end
            5'b11011: begin
                d.rd = w[11:7];
                d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            5'b11100: begin
                d.rd = w[11:7]; d.f3 = w[14:12]; d.rs1 = w[19:15];
                d.imm = (w[14:12] == 3'b000) ? {{20{w[31]}}, w[31:20]} : {20'd0, w[31:20]};
            end
            default: ;
        endcase
        return d;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        exp_t d;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        if (reset) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) begin
                check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
                check_eq("hold_insn", out_insn, prev_insn);
                check_eq("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (err) err_seen++;
            if (out_valid && out_ready) begin
                check_eq("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("last", {31'd0, out_last}, {31'd0, e.last});
                    if (e.raw) begin
                        check_eq("word", out_insn, e.word);
                    end else begin
                        d = decode(out_insn);
                        check_eq("rt_low2", {30'd0, out_insn[1:0]}, 32'd3);
                        check_eq("rt_op", {27'd0, d.op}, {27'd0, e.op});
                        check_eq("rt_rd", {27'd0, d.rd}, {27'd0, e.rd});
                        check_eq("rt_rs1", {27'd0, d.rs1}, {27'd0, e.rs1});
                        check_eq("rt_rs2", {27'd0, d.rs2}, {27'd0, e.rs2});
                        check_eq("rt_f3", {29'd0, d.f3}, {29'd0, e.f3});
                        check_eq("rt_f7", {25'd0, d.f7}, {25'd0, e.f7});
                        check_eq("rt_imm", d.imm, e.imm);
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_insn = out_insn;
            prev_last = out_last;
        end
    end

    task automatic send(input logic li, input logic [4:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        bit acc;
        acc = 0;
        @(negedge clock); #1;
        in_valid = 1'b1; in_li = li; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        for (int n = 0; n < 300; n++) begin
            acc = in_ready;
            @(posedge clock);
            if (acc) break;
            @(negedge clock); #1;
        end
        #1;
        in_valid = 1'b0;
        check_eq("accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clock); #1;
            if (exp_q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        check_eq("drain", {31'd0, ok}, 32'd1);
    endtask

    task automatic gen_one();
        logic [4:0]  op, rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        int          cat, s, lo, hi, r;
        bit          want_bad, legal;
        exp_t        e;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        f3 = 3'($urandom); f7 = 7'($urandom); imm = $urandom;
        cat = $urandom_range(0, 9);
        want_bad = ($urandom_range(0, 4) == 0);
        r = int'($urandom_range(0, 50000));
        op = 5'd0;
        case (cat)
            0: op = r_ops[$urandom_range(0, 1)];
            1, 2: begin
                op = (cat == 1) ? i_ops[$urandom_range(0, 4)] : 5'b01000;
                imm = want_bad ? (($urandom_range(0, 1) != 0) ? 2048 + r : -2049 - r)
                               : int'($urandom_range(0, 4095)) - 2048;
            end
            3: begin
                op = 5'b11000;
                if (!want_bad) imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                else if ($urandom_range(0, 1) != 0) imm = (int'($urandom_range(0, 4094)) - 2048) * 2 + 1;
                else imm = ($urandom_range(0, 1) != 0) ? 4096 + 2 * r : -4098 - 2 * r;
            end
            4: begin
                op = u_ops[$urandom_range(0, 1)];
                imm = ($urandom & 32'hFFFFF000) | (want_bad ? $urandom_range(1, 4095) : 0);
            end
            5: begin
                op = 5'b11011;
                if (!want_bad) imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                else if ($urandom_range(0, 1) != 0) imm = (int'($urandom_range(0, 1000)) - 500) * 2 + 1;
                else imm = ($urandom_range(0, 1) != 0) ? 1048576 + 2 * r : -1048578 - 2 * r;
            end
            6: begin
                op = 5'b11100;
                if (f3 == 3'b000) imm = int'($urandom_range(0, 4095)) - 2048;
            end
            7: op = bad_ops[$urandom_range(0, 5)];
            default: begin
                case ($urandom_range(0, 3))
                    0: imm = int'($urandom_range(0, 4095)) - 2048;
                    1: imm = $urandom;
                    2: imm = $urandom & 32'hFFFFF000;
                    default: imm = li_special[$urandom_range(0, 7)];
                endcase
            end
        endcase

        s = imm;
        legal = 0;
        e = mk_raw(32'd0, 1'b1);
        case (cat)
            0: begin legal = 1; e = mk_fld(op, rd, rs1, rs2, f3, f7, 32'd0, 1'b1); end
            1: begin legal = (s >= -2048 && s <= 2047); e = mk_fld(op, rd, rs1, 5'd0, f3, 7'd0, imm, 1'b1); end
            2: begin legal = (s >= -2048 && s <= 2047); e = mk_fld(op, 5'd0, rs1, rs2, f3, 7'd0, imm, 1'b1); end
            3: begin legal = (s >= -4096 && s <= 4094 && s % 2 == 0); e = mk_fld(op, 5'd0, rs1, rs2, f3, 7'd0, imm, 1'b1); end
            4: begin legal = ((imm & 32'hFFF) == 0); e = mk_fld(op, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm, 1'b1); end
            5: begin legal = (s >= -1048576 && s <= 1048574 && s % 2 == 0); e = mk_fld(op, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm, 1'b1); end
            6: begin
                if (f3 == 3'b000) begin
                    legal = (s >= -2048 && s <= 2047);
                    e = mk_fld(op, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, imm, 1'b1);
                end else begin
                    legal = (f3 != 3'b100);
                    e = mk_fld(op, rd, rs1, 5'd0, f3, 7'd0, imm & 32'hFFF, 1'b1);
                end
            end
            7: legal = 0;
            default: begin
                if (s >= -2048 && s <= 2047) begin
                    exp_q.push_back(mk_fld(5'b00100, rd, 5'd0, 5'd0, 3'd0, 7'd0, imm, 1'b1));
                end else begin
                    lo = ((s & 4095) ^ 2048) - 2048;
                    hi = s - lo;
                    exp_q.push_back(mk_fld(5'b01101, rd, 5'd0, 5'd0, 3'd0, 7'd0, hi, lo == 0));
                    if (lo != 0) exp_q.push_back(mk_fld(5'b00100, rd, rd, 5'd0, 3'd0, 7'd0, lo, 1'b1));
                end
            end
        endcase
        if (cat <= 7) begin
            if (legal) exp_q.push_back(e);
            else err_exp++;
        end
        send(cat > 7, op, f3, f7, rd, rs1, rs2, imm);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_li = 1'b0; in_opcode = 5'd0; in_funct3 = 3'd0;
        in_funct7 = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_insn", out_insn, 32'd0);
        check_eq("rst_out_last", {31'd0, out_last}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;

        ready_mode = 0;
        exp_q.push_back(mk_raw(32'h002081B3, 1'b1));
        send(1'b0, 5'b01100, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        #1;
        check_eq("add_latency_valid", {31'd0, out_valid}, 32'd1);
        check_eq("add_insn", out_insn, 32'h002081B3);
        drain();

        exp_q.push_back(mk_raw(32'hFE208EE3, 1'b1));
        send(1'b0, 5'b11000, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd4);
        drain();

        err_exp++;
        send(1'b0, 5'b11000, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd3);
        #1;
        check_eq("beq_odd_err", {31'd0, err}, 32'd1);
        check_eq("beq_odd_no_word", {31'd0, out_valid}, 32'd0);
        drain();

        exp_q.push_back(mk_raw(32'h123452B7, 1'b0));
        exp_q.push_back(mk_raw(32'h67828293, 1'b1));
        send(1'b1, 5'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        exp_q.push_back(mk_raw(32'h000010B7, 1'b0));
        exp_q.push_back(mk_raw(32'h80008093, 1'b1));
        send(1'b1, 5'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800);
        exp_q.push_back(mk_raw(32'h80000093, 1'b1));
        send(1'b1, 5'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd2048);
        exp_q.push_back(mk_raw(32'h00001137, 1'b1));
        send(1'b1, 5'd0, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h00001000);
        drain();

        ready_mode = 2;
        exp_q.push_back(mk_raw(32'h123452B7, 1'b0));
        exp_q.push_back(mk_raw(32'h67828293, 1'b1));
        send(1'b1, 5'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("bp_lui", out_insn, 32'h123452B7);
        end
        ready_mode = 0;
        @(negedge clock); #1;
        check_eq("bp_pend_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock); #1;
        check_eq("bp_addi_loaded", out_insn, 32'h67828293);
        check_eq("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        drain();

        ready_mode = 2;
        send(1'b1, 5'd0, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        #1;
        check_eq("mid_lui", out_insn, 32'h123452B7);
        check_eq("mid_pend_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock); #1;
        reset = 1'b1;
        @(negedge clock); #1;
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_insn", out_insn, 32'd0);
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check_eq("mid_no_addi", {31'd0, out_valid}, 32'd0);
        end
        ready_mode = 0;
        exp_q.push_back(mk_raw(32'h002081B3, 1'b1));
        send(1'b0, 5'b01100, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        drain();

        ready_mode = 1;
        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            gen_one();
        end
        drain();
        repeat (2) @(negedge clock);
        check_eq("err_count", err_seen, err_exp);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
